// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM encodings for the logic-op arbiter and its gate datapath.
package logic_op_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-wide bitwise gate selected by opcode; zero latency, no flow control.
// The reserved opcode yields an all-zero result with err raised.
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         default: begin
            y   = '0;
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter for two requesters feeding one bitwise unit; accept in N, rsp_valid in N+2.
// Readys only assert in IDLE, so a stalled response holds all new requests off until handshake.
module logic_op_arbiter
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OP_W-1:0]  req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OP_W-1:0]  req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);

   state_e           state_q, state_d;
   logic             last_grant_q;
   logic             id_q;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             grant_vld, grant_id;
   logic [WIDTH-1:0] unit_y;
   logic             unit_err;

   logic_op_unit #(.WIDTH(WIDTH)) u_unit (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .y   (unit_y),
      .err (unit_err)
   );

   // Under contention the requester not granted last time wins.
   always_comb begin
      state_d    = state_q;
      grant_vld  = 1'b0;
      grant_id   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               grant_vld  = 1'b1;
               grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_d    = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_vld) begin
            last_grant_q <= grant_id;
            id_q         <= grant_id;
            op_q         <= grant_id ? req1_op : req0_op;
            a_q          <= grant_id ? req1_a  : req0_a;
            b_q          <= grant_id ? req1_b  : req0_b;
         end
         if (state_q == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= unit_y;
            rsp_err   <= unit_err;
         end else if (state_q == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter at WIDTH=8 with hand-computed expectations.
module tb_logic_op_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready;
   logic [2:0] req0_op;
   logic [7:0] req0_a, req0_b;
   logic       req1_valid, req1_ready;
   logic [2:0] req1_op;
   logic [7:0] req1_a, req1_b;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [7:0] rsp_data;

   int n_checks = 0;
   int n_errors = 0;

   logic_op_arbiter #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one lone request, then follow it through EXEC, RESP and back to IDLE.
   task automatic run_op(input string tag, input bit who, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_y, input bit exp_err);
      step();
      rsp_ready = 1'b1;
      if (!who) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
      @(negedge clk);
      check({tag, "_rdy"}, who ? req1_ready : req0_ready, 1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check({tag, "_exec_vld"}, rsp_valid, 0);
      step();
      @(negedge clk);
      check({tag, "_vld"}, rsp_valid, 1);
      check({tag, "_data"}, rsp_data, exp_y);
      check({tag, "_id"}, rsp_id, who);
      check({tag, "_err"}, rsp_err, exp_err);
      step();
      @(negedge clk);
      check({tag, "_drop"}, rsp_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00;

      // Reset held two cycles with both requesters pending
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_rdy0", req0_ready, 0);
         check("rst_rdy1", req1_ready, 0);
         check("rst_vld", rsp_valid, 0);
         check("rst_data", rsp_data, 8'h00);
      end
      step();
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      run_op("and", 1'b0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
      check("and_hold", rsp_data, 8'h30);

      // Contention straight after reset: req0 first, then req1
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'hAA; req0_b = 8'h0F;
      req1_valid = 1'b1; req1_op = 3'd4; req1_a = 8'h00; req1_b = 8'h01;
      @(negedge clk);
      check("cont_rdy0", req0_ready, 1);
      check("cont_rdy1", req1_ready, 0);
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      check("cont_exec_rdy1", req1_ready, 0);
      step();
      @(negedge clk);
      check("cont_a_vld", rsp_valid, 1);
      check("cont_a_data", rsp_data, 8'hA5);
      check("cont_a_id", rsp_id, 0);
      step();
      @(negedge clk);
      check("cont_b_rdy1", req1_ready, 1);
      step();
      req1_valid = 1'b0;
      step();
      @(negedge clk);
      check("cont_b_vld", rsp_valid, 1);
      check("cont_b_data", rsp_data, 8'hFE);
      check("cont_b_id", rsp_id, 1);

      // Backpressure: response stalls while req1 waits
      step();
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22;
      req1_valid = 1'b1; req1_op = 3'd3; req1_a = 8'hFF; req1_b = 8'h0F;
      @(negedge clk);
      check("bp_rdy0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_vld", rsp_valid, 1);
         check("bp_data", rsp_data, 8'h33);
         check("bp_id", rsp_id, 0);
         check("bp_rdy1", req1_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_last_data", rsp_data, 8'h33);
      check("bp_last_rdy1", req1_ready, 0);
      step();
      @(negedge clk);
      check("bp_grant_rdy1", req1_ready, 1);
      check("bp_grant_vld", rsp_valid, 0);
      step();
      req1_valid = 1'b0;
      step();
      @(negedge clk);
      check("bp_b_data", rsp_data, 8'hF0);
      check("bp_b_id", rsp_id, 1);
      step();

      run_op("not", 1'b0, 3'd6, 8'h5A, 8'hFF, 8'hA5, 1'b0);
      run_op("rsvd", 1'b1, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1);
      run_op("xnor", 1'b0, 3'd5, 8'hC3, 8'hC3, 8'hFF, 1'b0);
      run_op("nor1", 1'b1, 3'd4, 8'h0F, 8'h30, 8'hC0, 1'b0);

      // Reset while an operation sits in EXEC
      step();
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hFF; req0_b = 8'hFF;
      @(negedge clk);
      check("rx_rdy0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rx_rst_rdy0", req0_ready, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rx_no_vld", rsp_valid, 0);
         step();
      end
      req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'h04; req1_b = 8'h08;
      @(negedge clk);
      check("rx_cont_rdy0", req0_ready, 1);
      check("rx_cont_rdy1", req1_ready, 0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
